reg_bank_ctrl: RTL and testbench

Parametrised register-bank controller: a DEPTH x DATA_W register array behind a single valid/ready request channel supporting READ, WRITE and a multi-cycle CLEAR sweep, plus a combinational debug read port. It generalises the fixed 16 x 16-bit control-unit/register-file pair into one reusable block. Responses are registered and carry an error flag for illegal requests. It sits between a bus-side requester and the datapath that consumes register contents.

---
 rtl/regbank_pkg.sv | 16 +
 rtl/reg_bank_array.sv | 53 +++++
 rtl/reg_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared encodings for the register-bank controller: request opcodes and FSM states.
package regbank_pkg;

  typedef enum logic [1:0] {
    OP_RSVD  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_array.sv
// DEPTH x DATA_W register storage: async reset to RST_VAL, one write port,
// two combinational read ports (request side and debug side).
module reg_bank_array
  import regbank_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                DEPTH   = 16,
  parameter int                ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DEPTH-1:0][DATA_W-1:0] words;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] word_q;

      // One register with its own decoded write enable; out-of-range
      // write addresses never match any register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= RST_VAL;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          word_q <= wdata;
        end
      end

      assign words[gi] = word_q;
    end
  endgenerate

  // Read multiplexers; addresses beyond DEPTH-1 fall through to zero.
  always_comb begin
    rdata    = '0;
    dbg_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = words[i];
      if (dbg_addr == ADDR_W'(i)) dbg_data = words[i];
    end
  end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register-bank controller: valid/ready request channel (READ/WRITE/CLEAR),
// one-cycle registered response pulse with error flag, debug read port.
module reg_bank_ctrl
  import regbank_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                DEPTH   = 16,
  parameter int                ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  op_e               op;
  logic              accept;
  logic              addr_ok;
  logic              req_bad;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign op      = op_e'(req_op);
  assign accept  = req_valid && (state_q == IDLE);
  // Only reachable when DEPTH is not a power of two.
  assign addr_ok = ({1'b0, req_addr} < DEPTH_EXT);
  // CLEAR ignores the address, so it can never be rejected.
  assign req_bad = (op == OP_RSVD) || ((op != OP_CLEAR) && !addr_ok);

  // Single write port shared by request writes and the clear sweep.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = req_addr;
    arr_wdata = req_data;
    if (state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = idx_q;
      arr_wdata = RST_VAL;
    end else if (accept && !req_bad && (op == OP_WRITE)) begin
      arr_we = 1'b1;
    end
  end

  // Next-state, sweep index and response computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            case (op)
              OP_READ: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = arr_rdata;
              end
              OP_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = req_data;
              end
              OP_CLEAR: begin
                state_d = CLEAR;
                idx_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = IDLE;
          idx_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = RST_VAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, sweep counter and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  reg_bank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RST_VAL(RST_VAL)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .waddr   (arr_waddr),
    .wdata   (arr_wdata),
    .raddr   (req_addr),
    .rdata   (arr_rdata),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: three instances (16x16, 12x16, 8x32).
module tb_reg_bank_ctrl;
  import regbank_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  exp_t q0[$], q1[$], q2[$];

  // shared request fields (DUT0/DUT1), DUT2 has its own wide data / narrow addr
  logic [1:0]  op;
  logic [3:0]  addr;
  logic [15:0] data;
  logic [2:0]  addr2;
  logic [31:0] data2;
  logic v0, v1, v2;

  logic rdy0, rv0, re0, busy0;
  logic [15:0] rd0, dbgd0;
  logic [3:0]  dbga0;
  logic rdy1, rv1, re1, busy1;
  logic [15:0] rd1, dbgd1;
  logic [3:0]  dbga1;
  logic rdy2, rv2, re2, busy2;
  logic [31:0] rd2, dbgd2;
  logic [2:0]  dbga2;

  reg_bank_ctrl #(.DATA_W(16), .DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_op(op),
    .req_addr(addr), .req_data(data), .rsp_valid(rv0), .rsp_data(rd0),
    .rsp_err(re0), .busy(busy0), .dbg_addr(dbga0), .dbg_data(dbgd0)
  );

  reg_bank_ctrl #(.DATA_W(16), .DEPTH(12)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_op(op),
    .req_addr(addr), .req_data(data), .rsp_valid(rv1), .rsp_data(rd1),
    .rsp_err(re1), .busy(busy1), .dbg_addr(dbga1), .dbg_data(dbgd1)
  );

  reg_bank_ctrl #(.DATA_W(32), .DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_op(op),
    .req_addr(addr2), .req_data(data2), .rsp_valid(rv2), .rsp_data(rd2),
    .rsp_err(re2), .busy(busy2), .dbg_addr(dbga2), .dbg_data(dbgd2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request for one cycle, optionally queueing its expected response.
  task automatic issue(input int dut, input logic [1:0] o, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ee,
                       input bit push);
    exp_t x;
    x.d = ed;
    x.e = ee;
    if (push) begin
      case (dut)
        0:       q0.push_back(x);
        1:       q1.push_back(x);
        default: q2.push_back(x);
      endcase
    end
    op    = o;
    addr  = a;
    data  = d[15:0];
    addr2 = a[2:0];
    data2 = d;
    case (dut)
      0:       v0 = 1'b1;
      1:       v1 = 1'b1;
      default: v2 = 1'b1;
    endcase
    $display("req dut%0d op=%0d addr=%0d data=%h", dut, o, a, d);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  // Pop the oldest expectation for this instance and compare.
  task automatic mon(input int dut, input logic [31:0] d, input logic e);
    exp_t x;
    int   sz;
    x = '0;
    case (dut)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    $display("rsp dut%0d data=%h err=%0b", dut, d, e);
    chk($sformatf("rsp_pending_dut%0d", dut), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      case (dut)
        0:       x = q0.pop_front();
        1:       x = q1.pop_front();
        default: x = q2.pop_front();
      endcase
      chk($sformatf("rsp_data_dut%0d", dut), d, x.d);
      chk($sformatf("rsp_err_dut%0d", dut), 32'(e), 32'(x.e));
    end
  endtask

  always @(negedge clk) if (!rst && rv0) mon(0, 32'(rd0), re0);
  always @(negedge clk) if (!rst && rv1) mon(1, 32'(rd1), re1);
  always @(negedge clk) if (!rst && rv2) mon(2, rd2, re2);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nr;
    v0 = 0; v1 = 0; v2 = 0; op = 0; addr = 0; data = 0; addr2 = 0; data2 = 0;
    dbga0 = 0; dbga1 = 0; dbga2 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_rsp_valid", 32'(rv0), 32'd0);
    chk("rst_rsp_data", 32'(rd0), 32'd0);
    chk("rst_rsp_err", 32'(re0), 32'd0);
    for (int a = 0; a < 16; a++) begin
      dbga0 = 4'(a);
      #1 chk($sformatf("rst_dbg%0d", a), 32'(dbgd0), 32'h0);
    end
    @(posedge clk);
    #1;

    // write then read same address back-to-back
    issue(0, OP_WRITE, 4'd3, 32'hBEEF, 32'hBEEF, 1'b0, 1'b1);
    issue(0, OP_READ, 4'd3, 32'h0, 32'hBEEF, 1'b0, 1'b1);
    chk("b2b_read_valid", 32'(rv0), 32'd1);
    dbga0 = 4'd3;
    #1 chk("dbg_after_write", 32'(dbgd0), 32'hBEEF);

    // fill
    for (int a = 0; a < 16; a++)
      issue(0, OP_WRITE, 4'(a), 32'h1000 + 32'(a), 32'h1000 + 32'(a), 1'b0, 1'b1);

    // reserved opcode leaves the register alone
    issue(0, OP_RSVD, 4'd5, 32'h1234, 32'h0, 1'b1, 1'b1);
    dbga0 = 4'd5;
    #1 chk("rsvd_no_write", 32'(dbgd0), 32'h1005);
    issue(0, OP_READ, 4'd5, 32'h0, 32'h1005, 1'b0, 1'b1);

    // full clear sweep
    issue(0, OP_CLEAR, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    n = 0;
    nr = 0;
    while (busy0 && n < 100) begin
      if (!rdy0) nr++;
      if (n == 5) begin
        dbga0 = 4'd4;
        #1 chk("sweep_mid_cleared4", 32'(dbgd0), 32'h0);
        dbga0 = 4'd5;
        #1 chk("sweep_mid_kept5", 32'(dbgd0), 32'h1005);
      end
      n++;
      @(posedge clk);
      #1;
    end
    chk("clear_busy_cycles", 32'(n), 32'd16);
    chk("clear_ready_low_cycles", 32'(nr), 32'd16);
    chk("clear_done_ready", 32'(rdy0), 32'd1);
    chk("clear_done_rsp_valid", 32'(rv0), 32'd1);
    for (int a = 0; a < 16; a++) begin
      dbga0 = 4'(a);
      #1 chk($sformatf("post_clear_dbg%0d", a), 32'(dbgd0), 32'h0);
    end

    // DEPTH=12 instance: address range limits
    issue(1, OP_READ, 4'd13, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1, OP_READ, 4'd11, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(1, OP_WRITE, 4'd12, 32'hAAAA, 32'h0, 1'b1, 1'b1);
    issue(1, OP_WRITE, 4'd11, 32'h7777, 32'h7777, 1'b0, 1'b1);
    dbga1 = 4'd12;
    #1 chk("d12_dbg_oob", 32'(dbgd1), 32'h0);
    dbga1 = 4'd11;
    #1 chk("d12_dbg11", 32'(dbgd1), 32'h7777);

    // 32-bit, 8-deep instance
    issue(2, OP_WRITE, 4'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(2, OP_READ, 4'd7, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(2, OP_CLEAR, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    n = 0;
    while (busy2 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("w32_clear_cycles", 32'(n), 32'd8);
    dbga2 = 3'd7;
    #1 chk("w32_dbg7_cleared", dbgd2, 32'h0);

    // reset in the middle of a sweep
    issue(0, OP_WRITE, 4'd12, 32'h5555, 32'h5555, 1'b0, 1'b1);
    issue(0, OP_CLEAR, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("midclr_busy", 32'(busy0), 32'd1);
    dbga0 = 4'd12;
    #1 chk("midclr_dbg12_kept", 32'(dbgd0), 32'h5555);
    rst = 1'b1;
    #1;
    chk("midclr_rst_ready", 32'(rdy0), 32'd1);
    chk("midclr_rst_busy", 32'(busy0), 32'd0);
    chk("midclr_rst_rsp_valid", 32'(rv0), 32'd0);
    chk("midclr_rst_dbg12", 32'(dbgd0), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midclr_idle_ready", 32'(rdy0), 32'd1);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
